alu_md_unit: RTL and testbench
==============================

Name: alu_md_unit

Overview:
- Parametrised execute-stage unit for the MIPS core: decodes alu_op/funct, computes single-cycle ALU results, and runs unsigned multiply and divide iteratively into HI/LO registers.
- Asserts stall to freeze the PC and register-file write for the duration of a MULTU/DIVU.
- Replaces the fixed 5-operation ALU decode with a WIDTH-generic unit that adds shifts, XOR/NOR, SLTU, MFHI/MFLO and multi-cycle arithmetic.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- SHW, 5, shift-amount width; must equal ceil(log2(WIDTH)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  instruction in execute is valid
- alu_op  in  2  main-control class: 00 add, 01 sub, 10 R-type, 11 OR (ori)
- funct  in  6  R-type function field
- shamt  in  SHW  shift amount
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt or immediate
- result  out  WIDTH  combinational result
- zero  out  1  result == 0
- stall  out  1  hold pipeline / PC this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset:
  - rst_n low (async) → state IDLE, hi = lo = 0, counter and internal regs cleared.
  - stall forced 0 while rst_n is low.
  - Reset mid-operation aborts it; HI/LO read 0 afterwards.
- Combinational decode:
  - alu_op 00 → a+b; 01 → a−b; 11 → a|b (all wrap mod 2^WIDTH, no overflow flag).
  - alu_op 10, funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
    - 101010 SLT: signed, result = {0…,1} or 0.
    - 101011 SLTU: unsigned compare.
    - 000000 SLL: b << shamt; 000010 SRL: b >> shamt, logical.
    - 010000 MFHI → hi; 010010 MFLO → lo.
    - 011001 MULTU, 011011 DIVU → result 0.
    - any other funct → result 0.
  - zero tracks result in every cycle.
- Start condition: start = op_valid & state==IDLE & alu_op==10 & funct ∈ {MULTU, DIVU}.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on start, latch a and b, clear counter, go to MUL or DIV.
  - MUL: shift-add, one bit per cycle; after exactly WIDTH cycles go DONE with {hi,lo} = a×b (2·WIDTH-bit unsigned product).
  - DIV: restoring division, one quotient bit per cycle; after WIDTH cycles go DONE with lo = a/b, hi = a%b.
  - DIV with b == 0: still takes WIDTH cycles; lo = all ones, hi = a.
  - DONE: hi/lo already visible; go IDLE unconditionally. start is never evaluated in DONE, so the still-present issuing instruction does not restart.
- stall:
  - stall = start | state∈{MUL,DIV}, so it is high in the issue cycle plus WIDTH busy cycles (WIDTH+1 cycles total).
  - stall is low in DONE, so the pipeline advances then.
- The core holds op_valid, alu_op, funct, a and b stable while stall is high. The unit itself uses only the latched operands.
- hi/lo change only at the MUL/DIV→DONE transition or at reset. Single-cycle ops never modify them.
- Back-to-back MULTU/DIVU: the second starts from IDLE in the cycle after DONE.
- MFHI issued in the cycle after DONE returns the new value.

Test Plan:
- Reset: hold rst_n low with op_valid=1, funct=MULTU → stall=0, hi=lo=0. Release → stall=1 in the same cycle.
- ALU ops, WIDTH=32:
  - SUB 5−7 → 0xFFFFFFFE, zero=0.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
  - SLL b=1, shamt=31 → 0x80000000.
  - NOR 0,0 → 0xFFFFFFFF.
  - alu_op 01 with a==b → zero=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - stall high exactly 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001.
  - MFLO next instruction → 1.
- DIVU 100/7 → lo=14, hi=2 after 33 stalled cycles. DIVU 9/0 → lo=0xFFFFFFFF, hi=9.
- Abort: pulse rst_n low at busy cycle 10 of a MULTU → stall drops immediately, hi=lo=0, next MULTU 3×4 → lo=12, hi=0.
- Back-to-back: MULTU 2×3 followed directly by DIVU 6/4 → DONE visible for one cycle with stall=0, then stall re-asserts; final lo=1, hi=2.

Source files
------------

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with iterative unsigned multiply/divide into HI/LO.
// Single-cycle operations are decoded combinationally; MULTU/DIVU take
// WIDTH busy cycles and hold the pipeline through stall.
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_reg,   state_next;
    logic [SHW-1:0]   cnt_reg,     cnt_next;
    logic [WIDTH-1:0] operand_reg, operand_next;   // latched b (multiplicand / divisor)
    logic [WIDTH-1:0] work_hi_reg, work_hi_next;   // partial product high / remainder
    logic [WIDTH-1:0] work_lo_reg, work_lo_next;   // multiplier bits / dividend->quotient
    logic [WIDTH-1:0] hi_reg,      hi_next;
    logic [WIDTH-1:0] lo_reg,      lo_next;

    logic             is_md;
    logic             start;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] mul_hi_step, mul_lo_step;
    logic [WIDTH-1:0] div_rem_step, div_quo_step;

    assign is_md = (alu_op == 2'b10) && ((funct == F_MULTU) || (funct == F_DIVU));
    assign start = op_valid && (state_reg == IDLE) && is_md;
    // Reset must not leak a stall to the PC while rst_n is held low.
    assign stall = rst_n && (start || (state_reg == MUL) || (state_reg == DIV));

    assign hi = hi_reg;
    assign lo = lo_reg;

    // One shift-add multiply step: add multiplicand when the LSB is set, then shift right.
    assign mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
    assign mul_hi_step = mul_sum[WIDTH:1];
    assign mul_lo_step = {mul_sum[0], work_lo_reg[WIDTH-1:1]};

    // One restoring-division step; an extra guard bit keeps the borrow unambiguous.
    assign div_shift    = {1'b0, work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_diff     = div_shift - {2'b00, operand_reg};
    assign div_ok       = ~div_diff[WIDTH+1];
    assign div_rem_step = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_step = {work_lo_reg[WIDTH-2:0], div_ok};

    // Single-cycle result decode; zero follows whatever the result is.
    always_comb begin
        result = '0;
        unique case (alu_op)
            2'b00: result = a + b;
            2'b01: result = a - b;
            2'b11: result = a | b;
            default: begin
                case (funct)
                    F_ADD:   result = a + b;
                    F_SUB:   result = a - b;
                    F_AND:   result = a & b;
                    F_OR:    result = a | b;
                    F_XOR:   result = a ^ b;
                    F_NOR:   result = ~(a | b);
                    F_SLT:   result = WIDTH'($signed(a) < $signed(b));
                    F_SLTU:  result = WIDTH'(a < b);
                    F_SLL:   result = b << shamt;
                    F_SRL:   result = b >> shamt;
                    F_MFHI:  result = hi_reg;
                    F_MFLO:  result = lo_reg;
                    default: result = '0;
                endcase
            end
        endcase
    end

    assign zero = (result == '0);

    // Next-state logic for the multiply/divide sequencer.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        operand_next = operand_reg;
        work_hi_next = work_hi_reg;
        work_lo_next = work_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    operand_next = b;
                    work_lo_next = a;
                    work_hi_next = '0;
                    cnt_next     = '0;
                    state_next   = (funct == F_MULTU) ? MUL : DIV;
                end
            end
            MUL: begin
                work_hi_next = mul_hi_step;
                work_lo_next = mul_lo_step;
                cnt_next     = cnt_reg + SHW'(1);
                if (cnt_reg == LAST_CNT) begin
                    hi_next    = mul_hi_step;
                    lo_next    = mul_lo_step;
                    state_next = DONE;
                end
            end
            DIV: begin
                work_hi_next = div_rem_step;
                work_lo_next = div_quo_step;
                cnt_next     = cnt_reg + SHW'(1);
                if (cnt_reg == LAST_CNT) begin
                    hi_next    = div_rem_step;
                    lo_next    = div_quo_step;
                    state_next = DONE;
                end
            end
            // The issuing instruction is still present here; never restart from DONE.
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            operand_reg <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            operand_reg <= operand_next;
            work_hi_reg <= work_hi_next;
            work_lo_reg <= work_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: scoreboard queues hold expected
// results pushed at issue time and popped when the DUT delivers them.
module tb_alu_md_unit;

    localparam int W = 32;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [4:0]   shamt = 5'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         zero;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] md_q[$];
    logic [W-1:0]   alu_q[$];

    typedef struct packed {
        logic [1:0]   op;
        logic [5:0]   f;
        logic [4:0]   sh;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
    } alu_case_t;

    alu_md_unit #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .alu_op(alu_op),
        .funct(funct), .shamt(shamt), .a(a), .b(b), .result(result),
        .zero(zero), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference for MULTU/DIVU: {hi, lo}.
    function automatic logic [2*W-1:0] md_model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        if (f == F_MULTU) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        else if (y == '0) p = {x, {W{1'b1}}};
        else              p = {x % y, x / y};
        return p;
    endfunction

    // Issue a MULTU/DIVU, hold it through DONE, count stalled cycles.
    task automatic run_md(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int n, output bit timeout);
        op_valid = 1'b1; alu_op = 2'b10; funct = f; a = x; b = y;
        n = 0; timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall) n++;
            else begin
                timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        op_valid = 1'b0; alu_op = 2'b00; funct = 6'b0;
    endtask

    task automatic test_reset();
        int n; bit to; logic [2*W-1:0] exp;
        rst_n = 1'b0;
        op_valid = 1'b1; alu_op = 2'b10; funct = F_MULTU; a = 32'd5; b = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        else $display("ok reset_stall");
        total++;
        if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
        else $display("ok reset_hilo");
        rst_n = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL release_stall got=%b want=1", stall); end
        else $display("ok release_stall");
        md_q.push_back(md_model(F_MULTU, 32'd5, 32'd6));
        run_md(F_MULTU, 32'd5, 32'd6, n, to);
        exp = md_q.pop_front();
        total++;
        if (to || n != W + 1) begin bad++; $display("FAIL reset_mul_stall got=%0d timeout=%0b want=%0d", n, to, W + 1); end
        else $display("ok reset_mul_stall cycles=%0d", n);
        total++;
        if ({hi, lo} !== exp) begin bad++; $display("FAIL reset_mul_hilo got=%h want=%h", {hi, lo}, exp); end
        else $display("ok reset_mul_hilo %h", exp);
    endtask

    task automatic test_alu();
        alu_case_t cases [13];
        logic [W-1:0] exp;
        cases = '{
            '{2'b10, 6'b100010, 5'd0,  32'd5,        32'd7,        32'hFFFF_FFFE},
            '{2'b10, 6'b101010, 5'd0,  32'hFFFF_FFFF, 32'd1,       32'd1},
            '{2'b10, 6'b101011, 5'd0,  32'hFFFF_FFFF, 32'd1,       32'd0},
            '{2'b10, 6'b000000, 5'd31, 32'd0,        32'd1,        32'h8000_0000},
            '{2'b10, 6'b100111, 5'd0,  32'd0,        32'd0,        32'hFFFF_FFFF},
            '{2'b01, 6'b000000, 5'd0,  32'h1234,     32'h1234,     32'd0},
            '{2'b00, 6'b000000, 5'd0,  32'hFFFF_FFFF, 32'd2,       32'd1},
            '{2'b11, 6'b000000, 5'd0,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF},
            '{2'b10, 6'b000010, 5'd4,  32'd0,        32'h8000_0000, 32'h0800_0000},
            '{2'b10, 6'b100110, 5'd0,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0},
            '{2'b10, 6'b100100, 5'd0,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00},
            '{2'b10, 6'b111111, 5'd0,  32'd3,        32'd4,        32'd0},
            '{2'b10, 6'b100000, 5'd0,  32'd7,        32'd8,        32'd15}
        };
        foreach (cases[i]) begin
            alu_q.push_back(cases[i].r);
            op_valid = 1'b1; alu_op = cases[i].op; funct = cases[i].f;
            shamt = cases[i].sh; a = cases[i].x; b = cases[i].y;
            #2;
            exp = alu_q.pop_front();
            total++;
            if (result !== exp || zero !== (exp == '0) || stall !== 1'b0) begin
                bad++;
                $display("FAIL alu_%0d got=%h zero=%b stall=%b want=%h zero=%b stall=0",
                         i, result, zero, stall, exp, (exp == '0));
            end else $display("ok alu_%0d op=%b funct=%b result=%h", i, cases[i].op, cases[i].f, result);
            @(posedge clk); #1;
        end
        op_valid = 1'b0; shamt = 5'd0;
    endtask

    task automatic test_multu();
        int n; bit to; logic [2*W-1:0] exp;
        md_q.push_back(md_model(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        run_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, to);
        exp = md_q.pop_front();
        total++;
        if (to || n != W + 1) begin bad++; $display("FAIL multu_stall got=%0d timeout=%0b want=%0d", n, to, W + 1); end
        else $display("ok multu_stall cycles=%0d", n);
        total++;
        if ({hi, lo} !== exp) begin bad++; $display("FAIL multu_hilo got=%h want=%h", {hi, lo}, exp); end
        else $display("ok multu_hilo %h", exp);
        op_valid = 1'b1; alu_op = 2'b10; funct = F_MFLO;
        #2;
        total++;
        if (result !== exp[W-1:0]) begin bad++; $display("FAIL mflo got=%h want=%h", result, exp[W-1:0]); end
        else $display("ok mflo %h", result);
        @(posedge clk); #1;
        funct = F_MFHI;
        #2;
        total++;
        if (result !== exp[2*W-1:W]) begin bad++; $display("FAIL mfhi got=%h want=%h", result, exp[2*W-1:W]); end
        else $display("ok mfhi %h", result);
        @(posedge clk); #1;
        op_valid = 1'b0; funct = 6'b0;
    endtask

    task automatic test_divu();
        logic [W-1:0] xs [2];
        logic [W-1:0] ys [2];
        int n; bit to; logic [2*W-1:0] exp;
        xs = '{32'd100, 32'd9};
        ys = '{32'd7, 32'd0};
        foreach (xs[i]) begin
            md_q.push_back(md_model(F_DIVU, xs[i], ys[i]));
            run_md(F_DIVU, xs[i], ys[i], n, to);
            exp = md_q.pop_front();
            total++;
            if (to || n != W + 1) begin bad++; $display("FAIL divu_%0d_stall got=%0d timeout=%0b want=%0d", i, n, to, W + 1); end
            else $display("ok divu_%0d_stall cycles=%0d", i, n);
            total++;
            if ({hi, lo} !== exp) begin bad++; $display("FAIL divu_%0d_hilo got=%h want=%h", i, {hi, lo}, exp); end
            else $display("ok divu_%0d_hilo %h", i, exp);
        end
    endtask

    task automatic test_abort();
        int n; bit to; logic [2*W-1:0] exp;
        op_valid = 1'b1; alu_op = 2'b10; funct = F_MULTU; a = 32'hFFFF_FFFF; b = 32'd3;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || {hi, lo} !== 64'd0) begin
            bad++; $display("FAIL abort_reset stall=%b hilo=%h want stall=0 hilo=0", stall, {hi, lo});
        end else $display("ok abort_reset");
        op_valid = 1'b0; funct = 6'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (stall !== 1'b0 || {hi, lo} !== 64'd0) begin
            bad++; $display("FAIL abort_idle stall=%b hilo=%h want stall=0 hilo=0", stall, {hi, lo});
        end else $display("ok abort_idle");
        md_q.push_back(md_model(F_MULTU, 32'd3, 32'd4));
        run_md(F_MULTU, 32'd3, 32'd4, n, to);
        exp = md_q.pop_front();
        total++;
        if (to || n != W + 1 || {hi, lo} !== exp) begin
            bad++; $display("FAIL abort_next_mul cycles=%0d hilo=%h want cycles=%0d hilo=%h", n, {hi, lo}, W + 1, exp);
        end else $display("ok abort_next_mul hilo=%h", exp);
    endtask

    task automatic test_back_to_back();
        int n; bit to; logic [2*W-1:0] exp;
        md_q.push_back(md_model(F_MULTU, 32'd2, 32'd3));
        md_q.push_back(md_model(F_DIVU, 32'd6, 32'd4));
        run_md(F_MULTU, 32'd2, 32'd3, n, to);
        exp = md_q.pop_front();
        total++;
        if (to || n != W + 1 || {hi, lo} !== exp) begin
            bad++; $display("FAIL b2b_mul cycles=%0d hilo=%h want cycles=%0d hilo=%h", n, {hi, lo}, W + 1, exp);
        end else $display("ok b2b_mul hilo=%h", exp);
        // Cycle right after DONE: the DIVU must start at once.
        op_valid = 1'b1; alu_op = 2'b10; funct = F_DIVU; a = 32'd6; b = 32'd4;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL b2b_restart stall=%b want=1", stall); end
        else $display("ok b2b_restart");
        run_md(F_DIVU, 32'd6, 32'd4, n, to);
        exp = md_q.pop_front();
        total++;
        if (to || n != W + 1 || {hi, lo} !== exp) begin
            bad++; $display("FAIL b2b_div cycles=%0d hilo=%h want cycles=%0d hilo=%h", n, {hi, lo}, W + 1, exp);
        end else $display("ok b2b_div hilo=%h", exp);
    endtask

    initial begin
        #1;
        test_reset();
        test_alu();
        test_multu();
        test_divu();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
